if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage.
- Drives PC_ID and INSTRUCTION_ID into decode.
- Owns the program counter and runs a req/ready handshake to instruction memory with variable latency.
- Handles stall from the hazard unit and branch redirect/flush from EX.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000013, instruction (addi x0,x0,0) inserted as bubble/flush

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
IF_ID_WRITE  input  1  1 = decode may accept; 0 = stall, IF/ID holds
PC_SRC  input  1  1-cycle redirect pulse from EX (branch taken)
PC_BRANCH  input  32  redirect target; bits [1:0] forced to 0
IMEM_REQ  output  1  fetch request to instruction memory
IMEM_ADDR  output  32  fetch address, word aligned
IMEM_RDATA  input  32  instruction, valid when IMEM_READY=1
IMEM_READY  input  1  memory completes the current request this cycle
PC_ID  output  32  PC of instruction in IF/ID
INSTRUCTION_ID  output  32  instruction in IF/ID
VALID_ID  output  1  1 = IF/ID holds a real instruction, 0 = bubble

Behaviour:
- Reset (async, rst_n=0) sets:
  - PC = RESET_PC; TARGET = 0; BUF = 0
  - PC_ID = 0; INSTRUCTION_ID = NOP_INSTR; VALID_ID = 0
  - state = FETCH; IMEM_REQ = 0 while rst_n=0
  - Release takes effect at the next rising edge; IMEM_REQ = 1 in the first cycle after release.
- Handshake:
  - IMEM_REQ and IMEM_ADDR are combinational from state/PC.
  - While IMEM_REQ=1 and IMEM_READY=0, IMEM_ADDR stays constant.
  - A transfer completes on the edge where REQ=1 and READY=1.
  - IMEM_READY while REQ=0 is ignored.
- States:
  - FETCH: REQ=1, ADDR=PC.
  - DROP: REQ=1, ADDR=PC (stale request being drained).
  - HOLD: REQ=0, fetched instruction parked in BUF.
- Priority per edge: PC_SRC > stall > normal.
- FETCH, PC_SRC=0:
  - READY=1, IF_ID_WRITE=1: IF/ID <= {PC, IMEM_RDATA, 1}; PC <= PC+4 (mod 2^32); stay FETCH. Back-to-back 1-cycle fetch gives 1 instr/cycle.
  - READY=1, IF_ID_WRITE=0: BUF <= IMEM_RDATA; IF/ID holds; go HOLD.
  - READY=0, IF_ID_WRITE=1: IF/ID <= {PC, NOP_INSTR, 0} (bubble).
  - READY=0, IF_ID_WRITE=0: IF/ID holds.
- HOLD, PC_SRC=0:
  - IF_ID_WRITE=1: IF/ID <= {PC, BUF, 1}; PC <= PC+4; go FETCH.
  - IF_ID_WRITE=0: everything holds.
- PC_SRC=1: IF/ID <= {PC_ID unchanged, NOP_INSTR, 0} regardless of IF_ID_WRITE (flush).
  - FETCH with READY=1: data discarded; PC <= PC_BRANCH; stay FETCH.
  - FETCH with READY=0: TARGET <= PC_BRANCH; go DROP (request cannot be withdrawn).
  - HOLD: BUF discarded; PC <= PC_BRANCH; go FETCH.
  - DROP: TARGET <= PC_BRANCH (latest redirect wins).
- DROP, PC_SRC=0:
  - READY=1: data discarded; PC <= TARGET; go FETCH.
  - READY=0: stay DROP.
  - While IF_ID_WRITE=1, IF/ID <= bubble each cycle.
- Redirect latency: first target instruction reaches IF/ID no earlier than 2 edges after the PC_SRC edge, plus memory latency.
- Invariants:
  - VALID_ID=0 always pairs with INSTRUCTION_ID = NOP_INSTR.
  - No instruction is fetched twice or skipped, except across a redirect.

Test Plan:
1. Reset, then IMEM_READY tied 1 returning addr-as-data, IF_ID_WRITE=1 -> IMEM_ADDR 0,4,8,…; PC_ID/INSTRUCTION_ID = 0/0, 4/4, 8/8 on successive cycles, VALID_ID=1 from the 2nd edge.
2. Memory latency 3 (READY every 3rd cycle) -> IMEM_ADDR held 3 cycles each; IF/ID shows 2 bubbles (NOP, VALID 0) between valid instructions; PC_ID advances 0,4,8.
3. IF_ID_WRITE=0 for 4 cycles, with a completion during the stall at addr 0x8 -> IF/ID frozen at PC 0x4; REQ=0 in HOLD; after release PC_ID=0x8 with the buffered data, then 0xC fetched.
4. PC_SRC=1, PC_BRANCH=0x100, same cycle as READY for addr 0x10 -> 0x10 data never appears with VALID 1; next IMEM_ADDR=0x100; flush bubble in IF/ID.
5. PC_SRC=1 (target 0x200) while waiting on 0x20, READY arrives 2 cycles later; second PC_SRC to 0x300 in between -> IMEM_ADDR stays 0x20 until READY, data dropped, next IMEM_ADDR=0x300.
6. rst_n low mid-wait in HOLD -> outputs immediately RESET_PC/NOP/VALID 0, REQ=0, BUF discarded; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a variable-latency req/ready memory
// port, plus the IF/ID register that feeds decode.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   IF_ID_WRITE       1 = decode accepts, 0 = stall (IF/ID holds)
//   PC_SRC, PC_BRANCH one-cycle redirect from EX and its target
//   IMEM_REQ/ADDR     fetch request and word address
//   IMEM_RDATA/READY  fetched word, and completion of the request
//   PC_ID, INSTRUCTION_ID, VALID_ID   IF/ID register contents
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        IF_ID_WRITE,
   input  logic        PC_SRC,
   input  logic [31:0] PC_BRANCH,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic [31:0] IMEM_RDATA,
   input  logic        IMEM_READY,
   output logic [31:0] PC_ID,
   output logic [31:0] INSTRUCTION_ID,
   output logic        VALID_ID
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DROP  = 2'd1,
      HOLD  = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } if_id_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] target_q, target_d;
   logic [31:0] buf_q, buf_d;
   if_id_t      id_q, id_d;

   logic [31:0] br_tgt;
   logic [31:0] pc_inc;
   logic        redirect;
   logic        stall;
   logic        advance;

   assign br_tgt   = {PC_BRANCH[31:2], 2'b00};
   assign pc_inc   = pc_q + 32'd4;
   assign redirect = PC_SRC;
   assign stall    = !PC_SRC && !IF_ID_WRITE;
   assign advance  = !PC_SRC && IF_ID_WRITE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         target_q <= '0;
         buf_q    <= '0;
         id_q     <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         buf_q    <= buf_d;
         id_q     <= id_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      target_d = target_q;
      buf_d    = buf_q;
      id_d     = id_q;
      unique case (1'b1)
         redirect: begin
            // Flush keeps PC_ID so the bubble still points near the branch.
            id_d = '{pc: id_q.pc, instr: NOP_INSTR, valid: 1'b0};
            case (state_q)
               FETCH: begin
                  if (IMEM_READY) begin
                     pc_d = br_tgt;
                  end else begin
                     // Outstanding request cannot be withdrawn.
                     target_d = br_tgt;
                     state_d  = DROP;
                  end
               end
               DROP: begin
                  if (IMEM_READY) begin
                     pc_d    = br_tgt;
                     state_d = FETCH;
                  end else begin
                     target_d = br_tgt;
                  end
               end
               HOLD: begin
                  pc_d    = br_tgt;
                  state_d = FETCH;
               end
               default: state_d = FETCH;
            endcase
         end
         stall: begin
            case (state_q)
               FETCH: begin
                  if (IMEM_READY) begin
                     buf_d   = IMEM_RDATA;
                     state_d = HOLD;
                  end
               end
               DROP: begin
                  if (IMEM_READY) begin
                     pc_d    = target_q;
                     state_d = FETCH;
                  end
               end
               HOLD: ;
               default: state_d = FETCH;
            endcase
         end
         advance: begin
            case (state_q)
               FETCH: begin
                  if (IMEM_READY) begin
                     id_d = '{pc: pc_q, instr: IMEM_RDATA, valid: 1'b1};
                     pc_d = pc_inc;
                  end else begin
                     id_d = '{pc: pc_q, instr: NOP_INSTR, valid: 1'b0};
                  end
               end
               DROP: begin
                  id_d = '{pc: pc_q, instr: NOP_INSTR, valid: 1'b0};
                  if (IMEM_READY) begin
                     pc_d    = target_q;
                     state_d = FETCH;
                  end
               end
               HOLD: begin
                  id_d    = '{pc: pc_q, instr: buf_q, valid: 1'b1};
                  pc_d    = pc_inc;
                  state_d = FETCH;
               end
               default: state_d = FETCH;
            endcase
         end
         default: ;
      endcase
   end

   // Request is masked during reset so memory sees nothing until release.
   always_comb begin
      IMEM_REQ  = rst_n && (state_q != HOLD);
      IMEM_ADDR = pc_q;
   end

   assign PC_ID          = id_q.pc;
   assign INSTRUCTION_ID = id_q.instr;
   assign VALID_ID       = id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table plus a reset-in-HOLD sequence.
// Memory returns a scrambled copy of the address so data != PC.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_id_write;
   logic        pc_src;
   logic [31:0] pc_branch;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] pc_id;
   logic [31:0] instruction_id;
   logic        valid_id;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ 32'h5A00_0000;

   if_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .IF_ID_WRITE    (if_id_write),
      .PC_SRC         (pc_src),
      .PC_BRANCH      (pc_branch),
      .IMEM_REQ       (imem_req),
      .IMEM_ADDR      (imem_addr),
      .IMEM_RDATA     (imem_rdata),
      .IMEM_READY     (imem_ready),
      .PC_ID          (pc_id),
      .INSTRUCTION_ID (instruction_id),
      .VALID_ID       (valid_id)
   );

   typedef struct {
      logic        w;
      logic        src;
      logic        rdy;
      logic [31:0] br;
      logic        e_req;
      logic        c_addr;
      logic [31:0] e_addr;
      logic        c_pc;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      logic        e_v;
   } vec_t;

   function automatic logic [31:0] d(input logic [31:0] a);
      return a ^ 32'h5A00_0000;
   endfunction

   function automatic vec_t mk(
      input logic w, input logic src, input logic rdy,
      input logic [31:0] br, input logic e_req,
      input logic c_addr, input logic [31:0] e_addr,
      input logic c_pc, input logic [31:0] e_pc,
      input logic [31:0] e_ins, input logic e_v);
      vec_t t;
      t.w = w; t.src = src; t.rdy = rdy; t.br = br;
      t.e_req = e_req; t.c_addr = c_addr; t.e_addr = e_addr;
      t.c_pc = c_pc; t.e_pc = e_pc; t.e_ins = e_ins; t.e_v = e_v;
      return t;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
      end
   endtask

   vec_t vt[27];

   initial begin
      //          w  s  r  br            req ca addr         cp pc            ins              v
      vt[0]  = mk(1, 0, 1, 0,            1, 1, 32'h0,      1, 32'h0,       d(32'h0),        1);
      vt[1]  = mk(1, 0, 1, 0,            1, 1, 32'h4,      1, 32'h4,       d(32'h4),        1);
      vt[2]  = mk(1, 0, 1, 0,            1, 1, 32'h8,      1, 32'h8,       d(32'h8),        1);
      vt[3]  = mk(1, 0, 0, 0,            1, 1, 32'hC,      1, 32'hC,       NOP,             0);
      vt[4]  = mk(1, 0, 0, 0,            1, 1, 32'hC,      1, 32'hC,       NOP,             0);
      vt[5]  = mk(1, 0, 1, 0,            1, 1, 32'hC,      1, 32'hC,       d(32'hC),        1);
      vt[6]  = mk(1, 0, 0, 0,            1, 1, 32'h10,     1, 32'h10,      NOP,             0);
      vt[7]  = mk(1, 0, 0, 0,            1, 1, 32'h10,     1, 32'h10,      NOP,             0);
      vt[8]  = mk(1, 0, 1, 0,            1, 1, 32'h10,     1, 32'h10,      d(32'h10),       1);
      vt[9]  = mk(0, 0, 0, 0,            1, 1, 32'h14,     1, 32'h10,      d(32'h10),       1);
      vt[10] = mk(0, 0, 1, 0,            1, 1, 32'h14,     1, 32'h10,      d(32'h10),       1);
      vt[11] = mk(0, 0, 1, 0,            0, 0, 32'h0,      1, 32'h10,      d(32'h10),       1);
      vt[12] = mk(0, 0, 0, 0,            0, 0, 32'h0,      1, 32'h10,      d(32'h10),       1);
      vt[13] = mk(1, 0, 0, 0,            0, 0, 32'h0,      1, 32'h14,      d(32'h14),       1);
      vt[14] = mk(1, 0, 1, 0,            1, 1, 32'h18,     1, 32'h18,      d(32'h18),       1);
      vt[15] = mk(1, 1, 1, 32'h101,      1, 1, 32'h1C,     1, 32'h18,      NOP,             0);
      vt[16] = mk(1, 0, 1, 0,            1, 1, 32'h100,    1, 32'h100,     d(32'h100),      1);
      vt[17] = mk(1, 1, 0, 32'h200,      1, 1, 32'h104,    1, 32'h100,     NOP,             0);
      vt[18] = mk(1, 1, 0, 32'h302,      1, 1, 32'h104,    1, 32'h100,     NOP,             0);
      vt[19] = mk(1, 0, 1, 0,            1, 1, 32'h104,    0, 32'h0,       NOP,             0);
      vt[20] = mk(1, 0, 1, 0,            1, 1, 32'h300,    1, 32'h300,     d(32'h300),      1);
      vt[21] = mk(0, 0, 1, 0,            1, 1, 32'h304,    1, 32'h300,     d(32'h300),      1);
      vt[22] = mk(0, 1, 0, 32'h400,      0, 0, 32'h0,      1, 32'h300,     NOP,             0);
      vt[23] = mk(1, 0, 1, 0,            1, 1, 32'h400,    1, 32'h400,     d(32'h400),      1);
      vt[24] = mk(1, 1, 1, 32'hFFFFFFFF, 1, 1, 32'h404,    1, 32'h400,     NOP,             0);
      vt[25] = mk(1, 0, 1, 0,            1, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, d(32'hFFFFFFFC), 1);
      vt[26] = mk(0, 0, 0, 0,            1, 1, 32'h0,      1, 32'hFFFFFFFC, d(32'hFFFFFFFC), 1);

      rst_n       = 1'b0;
      if_id_write = 1'b1;
      pc_src      = 1'b0;
      pc_branch   = '0;
      imem_ready  = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",   -1, {31'b0, imem_req}, 32'd0);
      chk("rst_pc_id", -1, pc_id,             32'h0);
      chk("rst_ins",   -1, instruction_id,    NOP);
      chk("rst_valid", -1, {31'b0, valid_id}, 32'd0);

      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         if_id_write = vt[i].w;
         pc_src      = vt[i].src;
         pc_branch   = vt[i].br;
         imem_ready  = vt[i].rdy;
         #1;
         chk("req", i, {31'b0, imem_req}, {31'b0, vt[i].e_req});
         if (vt[i].c_addr)
            chk("addr", i, imem_addr, vt[i].e_addr);
         @(posedge clk);
         #1;
         if (vt[i].c_pc)
            chk("pc_id", i, pc_id, vt[i].e_pc);
         chk("ins", i, instruction_id, vt[i].e_ins);
         chk("valid", i, {31'b0, valid_id}, {31'b0, vt[i].e_v});
      end

      // Park a fetch in HOLD, then reset mid-cycle.
      pc_src      = 1'b0;
      if_id_write = 1'b0;
      imem_ready  = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_req", 100, {31'b0, imem_req}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req",   101, {31'b0, imem_req}, 32'd0);
      chk("arst_pc_id", 101, pc_id,             32'h0);
      chk("arst_ins",   101, instruction_id,    NOP);
      chk("arst_valid", 101, {31'b0, valid_id}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n       = 1'b1;
      if_id_write = 1'b1;
      #1;
      chk("rel_req",  102, {31'b0, imem_req}, 32'd1);
      chk("rel_addr", 102, imem_addr,         32'h0);
      @(posedge clk);
      #1;
      chk("rel_pc_id", 103, pc_id,             32'h0);
      chk("rel_ins",   103, instruction_id,    d(32'h0));
      chk("rel_valid", 103, {31'b0, valid_id}, 32'd1);
      chk("rel_addr2", 103, imem_addr,         32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
